// File: rtl/qsfp_i2c_poller_if.sv
// qsfp_i2c_poller_if: classic Wishbone link between the poller
// (master) and the i2c_master_top slave port.
interface qsfp_i2c_poller_if;
  logic [2:0] wbm_adr_o;
  logic [7:0] wbm_dat_o;
  logic [7:0] wbm_dat_i;
  logic       wbm_we_o;
  logic       wbm_cyc_o;
  logic       wbm_stb_o;
  logic       wbm_ack_i;

  modport master (
    output wbm_adr_o, wbm_dat_o, wbm_we_o,
    output wbm_cyc_o, wbm_stb_o,
    input  wbm_dat_i, wbm_ack_i
  );

  modport slave (
    input  wbm_adr_o, wbm_dat_o, wbm_we_o,
    input  wbm_cyc_o, wbm_stb_o,
    output wbm_dat_i, wbm_ack_i
  );
endinterface

// File: rtl/qsfp_i2c_poller.sv
// qsfp_i2c_poller: autonomous one-byte QSFP register poller driving
// an i2c_master_top. QSFP_POLL_TIMEOUT_EN adds a TIP poll timeout.
module qsfp_i2c_poller #(
  parameter logic [15:0] PRESCALE    = 16'd99,
  parameter logic [6:0]  DEV_ADDR    = 7'h50,
  parameter logic [7:0]  REG_ADDR    = 8'd22,
  parameter logic [23:0] POLL_CYCLES = 24'd1000000
`ifdef QSFP_POLL_TIMEOUT_EN
  ,
  parameter logic [15:0] MAX_POLLS   = 16'd4096
`endif
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_n_i,
  input  logic              enable_i,
  qsfp_i2c_poller_if.master wbm,
  output logic [7:0]        data_o,
  output logic              valid_o,
  output logic              err_o,
  output logic              timeout_o,
  output logic              busy_o,
  output logic              done_o
);

  typedef enum logic [3:0] {
    S_INIT_LO, S_INIT_HI, S_INIT_CTR, S_IDLE,
    S_TXR, S_CR, S_SR, S_RXR,
    S_STOP_CR, S_STOP_SR, S_TO_CR,
    S_FAIL, S_FINISH
  } state_t;

  state_t      state, state_nx;
  logic [1:0]  step, step_nx;
  logic [23:0] poll_cnt;
  logic        access;
  logic        go;
  logic [2:0]  go_adr;
  logic [7:0]  go_dat;
  logic        go_we;
  logic        acked;
  logic        tip, al, rxack;
  logic        to_hit;
  logic        start;
  logic [7:0]  txr_val, cr_val;

  assign acked = wbm.wbm_cyc_o & wbm.wbm_ack_i;
  assign rxack = wbm.wbm_dat_i[7];
  assign al    = wbm.wbm_dat_i[5];
  assign tip   = wbm.wbm_dat_i[1];
  assign start = (state == S_IDLE) &&
                 (state_nx == S_TXR);

  // Per-step TXR and CR command bytes
  always_comb begin
    txr_val = {DEV_ADDR, 1'b1};
    cr_val  = 8'h90;
    unique case (step)
      2'd0: txr_val = {DEV_ADDR, 1'b0};
      2'd1: begin
        txr_val = REG_ADDR;
        cr_val  = 8'h10;
      end
      2'd2: txr_val = {DEV_ADDR, 1'b1};
      2'd3: cr_val  = 8'h68;
      default: ;
    endcase
  end

  // Next state and Wishbone access request
  always_comb begin
    state_nx = state;
    step_nx  = step;
    access   = 1'b0;
    go_adr   = 3'd4;
    go_dat   = 8'h00;
    go_we    = 1'b0;
    unique case (state)
      S_INIT_LO: begin
        access = 1'b1;
        go_adr = 3'd0;
        go_dat = PRESCALE[7:0];
        go_we  = 1'b1;
        if (acked) state_nx = S_INIT_HI;
      end
      S_INIT_HI: begin
        access = 1'b1;
        go_adr = 3'd1;
        go_dat = PRESCALE[15:8];
        go_we  = 1'b1;
        if (acked) state_nx = S_INIT_CTR;
      end
      S_INIT_CTR: begin
        access = 1'b1;
        go_adr = 3'd2;
        go_dat = 8'h80;
        go_we  = 1'b1;
        if (acked) state_nx = S_IDLE;
      end
      S_IDLE: begin
        if (poll_cnt == 24'd0 && enable_i) begin
          state_nx = S_TXR;
          step_nx  = 2'd0;
        end
      end
      S_TXR: begin
        access = 1'b1;
        go_adr = 3'd3;
        go_dat = txr_val;
        go_we  = 1'b1;
        if (acked) state_nx = S_CR;
      end
      S_CR: begin
        access = 1'b1;
        go_dat = cr_val;
        go_we  = 1'b1;
        if (acked) state_nx = S_SR;
      end
      S_SR: begin
        access = 1'b1;
        if (acked) begin
          if (to_hit)
            state_nx = S_TO_CR;
          else if (tip)
            state_nx = S_SR;
          else if (al)
            state_nx = S_FAIL;
          else if (step != 2'd3 && rxack)
            state_nx = S_STOP_CR;
          else if (step == 2'd3)
            state_nx = S_RXR;
          else begin
            step_nx  = step + 2'd1;
            state_nx = (step == 2'd2) ? S_CR : S_TXR;
          end
        end
      end
      S_RXR: begin
        access = 1'b1;
        go_adr = 3'd3;
        if (acked) state_nx = S_FINISH;
      end
      S_STOP_CR: begin
        access = 1'b1;
        go_dat = 8'h40;
        go_we  = 1'b1;
        if (acked) state_nx = S_STOP_SR;
      end
      S_STOP_SR: begin
        access = 1'b1;
        if (acked) begin
          if (to_hit)
            state_nx = S_TO_CR;
          else if (!tip)
            state_nx = S_FAIL;
        end
      end
      S_TO_CR: begin
        access = 1'b1;
        go_dat = 8'h40;
        go_we  = 1'b1;
        if (acked) state_nx = S_FINISH;
      end
      S_FAIL:   state_nx = S_FINISH;
      S_FINISH: state_nx = S_IDLE;
      default:  state_nx = S_INIT_LO;
    endcase
  end

  // A new access launches only once cyc has dropped, which
  // guarantees an idle bus cycle between accesses.
  assign go = access & ~wbm.wbm_cyc_o;

  // FSM state register
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      state <= S_INIT_LO;
      step  <= 2'd0;
    end else begin
      state <= state_nx;
      step  <= step_nx;
    end
  end

  // Registered Wishbone master signals, held until ack
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      wbm.wbm_cyc_o <= 1'b0;
      wbm.wbm_stb_o <= 1'b0;
      wbm.wbm_we_o  <= 1'b0;
      wbm.wbm_adr_o <= 3'd0;
      wbm.wbm_dat_o <= 8'h00;
    end else if (go) begin
      wbm.wbm_cyc_o <= 1'b1;
      wbm.wbm_stb_o <= 1'b1;
      wbm.wbm_we_o  <= go_we;
      wbm.wbm_adr_o <= go_adr;
      wbm.wbm_dat_o <= go_dat;
    end else if (acked) begin
      wbm.wbm_cyc_o <= 1'b0;
      wbm.wbm_stb_o <= 1'b0;
      wbm.wbm_we_o  <= 1'b0;
    end
  end

  // Status outputs and inter-poll counter
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      data_o   <= 8'h00;
      valid_o  <= 1'b0;
      err_o    <= 1'b0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      poll_cnt <= POLL_CYCLES;
    end else begin
      done_o <= (state == S_FINISH);
      if (state == S_IDLE && poll_cnt != 24'd0)
        poll_cnt <= poll_cnt - 24'd1;
      if (start) begin
        busy_o <= 1'b1;
        err_o  <= 1'b0;
      end
      if (state == S_RXR && acked) begin
        data_o  <= wbm.wbm_dat_i;
        valid_o <= 1'b1;
      end
      if (to_hit || state == S_FAIL)
        err_o <= 1'b1;
      if (state == S_FINISH) begin
        busy_o   <= 1'b0;
        poll_cnt <= POLL_CYCLES;
      end
    end
  end

`ifdef QSFP_POLL_TIMEOUT_EN
  logic [15:0] polls;
  logic        in_wait;

  assign in_wait = (state == S_SR) ||
                   (state == S_STOP_SR);
  assign to_hit  = in_wait && acked && tip &&
                   (polls == MAX_POLLS - 16'd1);

  // Count busy SR reads within one wait
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      polls     <= 16'd0;
      timeout_o <= 1'b0;
    end else begin
      if (!in_wait)
        polls <= 16'd0;
      else if (acked && tip)
        polls <= polls + 16'd1;
      if (start)
        timeout_o <= 1'b0;
      else if (to_hit)
        timeout_o <= 1'b1;
    end
  end
`else
  assign to_hit    = 1'b0;
  assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_qsfp_i2c_poller.sv
// tb_qsfp_i2c_poller: bench with an i2c_master_top register model
// and a queue of expected Wishbone writes.
module tb_qsfp_i2c_poller;
  localparam logic [23:0] POLL = 24'd30;
  localparam logic [7:0]  REG  = 8'd22;
  localparam logic [6:0]  DEV  = 7'h50;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [7:0] data;
  logic       valid, err, tmo, busy, done;

  qsfp_i2c_poller_if bus();

  always #5 clk = ~clk;

  qsfp_i2c_poller #(
    .POLL_CYCLES(POLL)
`ifdef QSFP_POLL_TIMEOUT_EN
    ,
    .MAX_POLLS(16'd8)
`endif
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_n_i (rst_n),
    .enable_i   (enable),
    .wbm        (bus),
    .data_o     (data),
    .valid_o    (valid),
    .err_o      (err),
    .timeout_o  (tmo),
    .busy_o     (busy),
    .done_o     (done)
  );

  typedef struct {
    int         dly;
    bit         present;
    bit         al;
    logic [7:0] rx;
    int         kind;
    bit         e_err;
    logic [7:0] e_data;
  } vec_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [10:0] exp_q[$];

  int          ack_dly = 0;
  bit          present = 1'b1;
  bit          al_f = 1'b0;
  bit          stuck = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  int          dly_cnt = 0;
  bit          in_acc = 1'b0;
  int          tip_cnt = 0;
  bit          rxack = 1'b0;
  logic [7:0]  rxr = 8'hFF;
  logic [7:0]  txr = 8'h00;
  logic [7:0]  reg_ptr = 8'h00;
  logic [11:0] cap;
  int          sr_cnt = 0;
  int          sr_before_40 = 0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic push_w(input logic [2:0] a,
                        input logic [7:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic push_init();
    push_w(3'd0, 8'h63);
    push_w(3'd1, 8'h00);
    push_w(3'd2, 8'h80);
  endtask

  task automatic push_good();
    push_w(3'd3, {DEV, 1'b0});
    push_w(3'd4, 8'h90);
    push_w(3'd3, REG);
    push_w(3'd4, 8'h10);
    push_w(3'd3, {DEV, 1'b1});
    push_w(3'd4, 8'h90);
    push_w(3'd4, 8'h68);
  endtask

  // I2C core register model: answers one access, updates state
  task automatic complete();
    logic [10:0] e;
    logic        tip;
    if (ack_dly != 0)
      check("bus_stable",
            {20'd0, bus.wbm_adr_o, bus.wbm_dat_o, bus.wbm_we_o},
            {20'd0, cap});
    if (bus.wbm_we_o) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_write: got adr %0d dat %0h want none",
                 bus.wbm_adr_o, bus.wbm_dat_o);
      end else begin
        e = exp_q.pop_front();
        if ({bus.wbm_adr_o, bus.wbm_dat_o} !== e) begin
          n_bad++;
          $display("FAIL write: got %0d/%0h want %0d/%0h",
                   bus.wbm_adr_o, bus.wbm_dat_o, e[10:8], e[7:0]);
        end
      end
      if (bus.wbm_adr_o == 3'd3) txr = bus.wbm_dat_o;
      if (bus.wbm_adr_o == 3'd4) begin
        if (bus.wbm_dat_o == 8'h40) begin
          sr_before_40 = sr_cnt;
          tip_cnt = 1;
        end else if (bus.wbm_dat_o[4]) begin
          tip_cnt = 2;
          rxack = !present;
          if (!bus.wbm_dat_o[7]) reg_ptr = txr;
        end else if (bus.wbm_dat_o[5]) begin
          tip_cnt = 2;
          rxr = (reg_ptr == REG) ? rx_byte : 8'hFF;
        end
      end
      sr_cnt = 0;
      bus.wbm_dat_i = 8'h00;
    end else if (bus.wbm_adr_o == 3'd4) begin
      tip = stuck || (tip_cnt != 0);
      if (tip_cnt != 0) tip_cnt--;
      sr_cnt++;
      bus.wbm_dat_i = {rxack, 1'b0, al_f, 3'b000, tip, 1'b0};
    end else if (bus.wbm_adr_o == 3'd3) begin
      bus.wbm_dat_i = rxr;
    end else begin
      bus.wbm_dat_i = 8'h00;
    end
  endtask

  // Slave responder with programmable ack delay
  always @(negedge clk) begin
    if (!rst_n) begin
      bus.wbm_ack_i = 1'b0;
      bus.wbm_dat_i = 8'h00;
      in_acc = 1'b0;
      tip_cnt = 0;
    end else if (bus.wbm_ack_i) begin
      bus.wbm_ack_i = 1'b0;
    end else if (bus.wbm_cyc_o && bus.wbm_stb_o) begin
      if (!in_acc) begin
        in_acc = 1'b1;
        dly_cnt = 0;
        cap = {bus.wbm_adr_o, bus.wbm_dat_o, bus.wbm_we_o};
      end
      if (dly_cnt < ack_dly) begin
        dly_cnt++;
      end else begin
        complete();
        bus.wbm_ack_i = 1'b1;
        in_acc = 1'b0;
      end
    end
  end

  task automatic wait_done(input string name);
    int k = 0;
    while (!done && k < 3000) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (!done) begin
      n_bad++;
      $display("FAIL %s: got no done_o want done_o in %0d cycles",
               name, k);
    end
  endtask

  task automatic check_end(input string name, input bit e_err,
                           input logic [7:0] e_data,
                           input bit e_valid, input bit e_to);
    check({name, "/err"}, {31'd0, err}, {31'd0, e_err});
    check({name, "/data"}, {24'd0, data}, {24'd0, e_data});
    check({name, "/valid"}, {31'd0, valid}, {31'd0, e_valid});
    check({name, "/timeout"}, {31'd0, tmo}, {31'd0, e_to});
    check({name, "/busy"}, {31'd0, busy}, 32'd0);
    check({name, "/queue"}, exp_q.size(), 32'd0);
    @(negedge clk);
    check({name, "/done_pulse"}, {31'd0, done}, 32'd0);
  endtask

  task automatic run_vec(input string name, input vec_t v);
    ack_dly = v.dly;
    present = v.present;
    al_f = v.al;
    stuck = 1'b0;
    rx_byte = v.rx;
    if (v.kind == 0) begin
      push_good();
    end else begin
      push_w(3'd3, {DEV, 1'b0});
      push_w(3'd4, 8'h90);
      if (v.kind == 1) push_w(3'd4, 8'h40);
    end
    enable = 1'b1;
    wait_done(name);
    enable = 1'b0;
    check_end(name, v.e_err, v.e_data, 1'b1, 1'b0);
  endtask

  vec_t vt[6];

  initial begin
    int gap;
    int k;
    vt[0] = '{0, 1'b1, 1'b0, 8'h2A, 0, 1'b0, 8'h2A};
    vt[1] = '{0, 1'b0, 1'b0, 8'h00, 1, 1'b1, 8'h2A};
    vt[2] = '{5, 1'b1, 1'b0, 8'h2A, 0, 1'b0, 8'h2A};
    vt[3] = '{1, 1'b1, 1'b0, 8'hC5, 0, 1'b0, 8'hC5};
    vt[4] = '{0, 1'b1, 1'b1, 8'h00, 2, 1'b1, 8'hC5};
    vt[5] = '{2, 1'b0, 1'b0, 8'h00, 1, 1'b1, 8'hC5};

    bus.wbm_ack_i = 1'b0;
    bus.wbm_dat_i = 8'h00;
    rst_n = 1'b0;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    check("rst/cyc", {31'd0, bus.wbm_cyc_o}, 32'd0);
    check("rst/outs", {20'd0, data, valid, err, tmo, busy},
          32'd0);
    check("rst/done", {31'd0, done}, 32'd0);

    push_init();
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    check("init/queue", exp_q.size(), 32'd0);
    check("init/busy", {31'd0, busy}, 32'd0);

    for (int i = 0; i < 6; i++)
      run_vec($sformatf("vec%0d", i), vt[i]);

    ack_dly = 0;
    present = 1'b1;
    al_f = 1'b0;
    rx_byte = 8'h3C;
    push_good();
    push_good();
    enable = 1'b1;
    wait_done("gap_a");
    gap = 0;
    while (!busy && gap < 200) begin
      @(negedge clk);
      gap++;
    end
    check("poll_gap", gap, POLL + 1);
    wait_done("gap_b");
    enable = 1'b0;
    check_end("gap_b", 1'b0, 8'h3C, 1'b1, 1'b0);

    rx_byte = 8'h2A;
    push_good();
    enable = 1'b1;
    k = 0;
    while (!(exp_q.size() == 1 && bus.wbm_cyc_o &&
             !bus.wbm_we_o) && k < 500) begin
      @(negedge clk);
      k++;
    end
    check("s2_reached", {31'd0, k < 500}, 32'd1);
    rst_n = 1'b0;
    enable = 1'b0;
    @(negedge clk);
    check("midrst/cyc", {31'd0, bus.wbm_cyc_o}, 32'd0);
    check("midrst/outs", {20'd0, data, valid, err, tmo, busy},
          32'd0);
    check("midrst/done", {31'd0, done}, 32'd0);
    exp_q.delete();
    push_init();
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    check("reinit/queue", exp_q.size(), 32'd0);

`ifdef QSFP_POLL_TIMEOUT_EN
    stuck = 1'b1;
    present = 1'b1;
    ack_dly = 0;
    push_w(3'd3, {DEV, 1'b0});
    push_w(3'd4, 8'h90);
    push_w(3'd4, 8'h40);
    enable = 1'b1;
    wait_done("tmo");
    enable = 1'b0;
    check("tmo/sr_reads", sr_before_40, 32'd8);
    check_end("tmo", 1'b1, 8'h00, 1'b0, 1'b1);
    stuck = 1'b0;
`endif

    run_vec("after_rst", vt[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
